// File: rtl/fetch_mem_if_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Interface : fetch_mem_if_if
// Purpose   : Bundles the three handshake channels of the fetch memory stage:
//             PC input from the PC generator, instruction-memory
//             request/answer, and instruction output to the issue queue.
// Modports  : slave  - the fetch_mem_if stage itself
//             master - the environment around it (PC gen, memory, issue queue)
// Revision  : 1.0 - initial release
// ============================================================================
interface fetch_mem_if_if;
    // PC generator -> stage
    logic        pc_valid_i;
    logic [63:0] pc_i;
    logic        pc_ready_o;
    // stage -> instruction memory request
    logic        mem_req_valid_o;
    logic        mem_req_ready_i;
    logic [63:0] mem_req_addr_o;
    // instruction memory answer -> stage
    logic        mem_ans_valid_i;
    logic        mem_ans_ready_o;
    logic [31:0] mem_ans_data_i;
    logic        mem_ans_except_i;
    // stage -> issue queue
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [63:0] instr_pc_o;
    logic        instr_except_o;
    logic [1:0]  instr_except_code_o;

    modport slave (
        input  pc_valid_i, pc_i, mem_req_ready_i,
        input  mem_ans_valid_i, mem_ans_data_i, mem_ans_except_i,
        input  instr_ready_i,
        output pc_ready_o, mem_req_valid_o, mem_req_addr_o, mem_ans_ready_o,
        output instr_valid_o, instr_o, instr_pc_o, instr_except_o, instr_except_code_o
    );

    modport master (
        output pc_valid_i, pc_i, mem_req_ready_i,
        output mem_ans_valid_i, mem_ans_data_i, mem_ans_except_i,
        output instr_ready_i,
        input  pc_ready_o, mem_req_valid_o, mem_req_addr_o, mem_ans_ready_o,
        input  instr_valid_o, instr_o, instr_pc_o, instr_except_o, instr_except_code_o
    );
endinterface
`default_nettype wire

// File: rtl/fetch_mem_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module    : fetch_mem_if
// Purpose   : Fetch stage after the PC generator. Issues instruction-memory
//             requests, tracks in-flight PCs in an in-order FIFO, pairs each
//             memory answer with its PC and forwards it to the issue queue
//             with zero latency. On flush, answers still owed to squashed
//             requests are counted in drop_cnt and silently discarded.
// Ports     : clk_i    - clock
//             rst_ni   - asynchronous active-low reset
//             flush_i  - squash every outstanding fetch
//             bus      - fetch_mem_if_if.slave (PC, mem req/ans, instr out)
// Params    : MAX_OUTSTANDING - in-flight limit (live + squashed), power of 2, >= 2
//             BOOT_PC         - unused, kept for frontend parameter symmetry
// Macros    : FETCH_MISALIGN_CHECK_EN - PCs with pc[1:0] != 0 skip memory and
//             are returned as misaligned-fetch exceptions (code 1)
// Revision  : 1.0 - initial release
// ============================================================================
module fetch_mem_if #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [63:0] BOOT_PC         = 64'h0
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          flush_i,
    fetch_mem_if_if.slave bus
);
    localparam int unsigned    PTR_W   = $clog2(MAX_OUTSTANDING);
    localparam int unsigned    CNT_W   = PTR_W + 1;
    localparam logic [CNT_W:0] MAX_OCC = (CNT_W + 1)'(MAX_OUTSTANDING);

    // PC FIFO storage: {pc, local_exc}
    logic [63:0]                pc_mem_q [MAX_OUTSTANDING];
    logic [MAX_OUTSTANDING-1:0] exc_q;

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;    // all FIFO entries
    logic [CNT_W-1:0] live_q,   live_d;   // entries still owed a memory answer
    logic [CNT_W-1:0] drop_q,   drop_d;   // answers owed to squashed requests

    logic             w_unused_boot_pc;
    logic             w_misalign;
    logic             w_room;
    logic [CNT_W:0]   w_occ;
    logic [CNT_W:0]   w_owed;
    logic             w_push;
    logic             w_pop;
    logic             w_drop_dec;
    logic             w_head_valid;
    logic             w_head_exc;
    logic [63:0]      w_head_pc;

    logic             w_req_valid;
    logic             w_pc_ready;
    logic             w_ans_ready;
    logic             w_instr_valid;
    logic [31:0]      w_instr;
    logic [63:0]      w_instr_pc;
    logic             w_instr_except;
    logic [1:0]       w_instr_code;

    assign w_unused_boot_pc = ^BOOT_PC;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign w_misalign = (bus.pc_i[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    // Room is computed from registered counts only, so a same-cycle pop
    // never makes room for a same-cycle push.
    assign w_occ  = {1'b0, cnt_q} + {1'b0, drop_q};
    assign w_room = (w_occ < MAX_OCC);
    assign w_owed = {1'b0, live_q} + {1'b0, drop_q};

    // ------------------------------------------------------------------
    // Request side
    // ------------------------------------------------------------------
    assign w_req_valid = bus.pc_valid_i & w_room & ~flush_i & ~w_misalign;
    // Misaligned PCs are accepted locally without a memory handshake.
    assign w_pc_ready  = w_misalign ? (bus.pc_valid_i & w_room & ~flush_i)
                                    : (w_req_valid & bus.mem_req_ready_i);
    assign w_push      = w_pc_ready;

    assign w_head_valid = (cnt_q != '0);
    assign w_head_exc   = exc_q[rd_ptr_q];
    assign w_head_pc    = pc_mem_q[rd_ptr_q];

    // ------------------------------------------------------------------
    // Answer routing and instruction output
    // ------------------------------------------------------------------
    always_comb begin
        w_ans_ready    = 1'b0;
        w_instr_valid  = 1'b0;
        w_instr        = 32'h0;
        w_instr_pc     = 64'h0;
        w_instr_except = 1'b0;
        w_instr_code   = 2'd0;
        w_pop          = 1'b0;
        w_drop_dec     = 1'b0;

        if (flush_i) begin
            // Swallow any same-cycle answer; it is accounted for in drop_d.
            w_ans_ready = 1'b1;
        end else begin
            if (w_head_valid && w_head_exc) begin
                // Locally raised exception needs no memory answer, so it may
                // drain even while squashed answers are still being dropped.
                w_instr_valid  = 1'b1;
                w_instr_pc     = w_head_pc;
                w_instr_except = 1'b1;
                w_instr_code   = 2'd1;
                w_pop          = bus.instr_ready_i;
            end else if (w_head_valid && (drop_q == '0)) begin
                w_instr_valid  = bus.mem_ans_valid_i;
                w_ans_ready    = bus.instr_ready_i;
                w_instr        = bus.mem_ans_except_i ? 32'h0 : bus.mem_ans_data_i;
                w_instr_pc     = w_head_pc;
                w_instr_except = bus.mem_ans_except_i;
                w_pop          = bus.mem_ans_valid_i & bus.instr_ready_i;
            end

            // Answers in order: while squashed answers are owed, every
            // incoming answer belongs to a squashed request.
            if (drop_q != '0) begin
                w_ans_ready = 1'b1;
                w_drop_dec  = bus.mem_ans_valid_i;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state for pointers and counters
    // ------------------------------------------------------------------
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        live_d   = live_q;
        drop_d   = drop_q;

        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
            live_d   = '0;
            // Every live entry still owes an answer; a same-cycle answer
            // settles one of them immediately.
            if (bus.mem_ans_valid_i && (w_owed != '0)) begin
                drop_d = CNT_W'(w_owed - (CNT_W + 1)'(1));
            end else begin
                drop_d = CNT_W'(w_owed);
            end
        end else begin
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            cnt_d  = cnt_q + CNT_W'(w_push) - CNT_W'(w_pop);
            live_d = live_q + CNT_W'(w_push & ~w_misalign)
                            - CNT_W'(w_pop & ~w_head_exc);
            if (w_drop_dec) begin
                drop_d = drop_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            live_q   <= '0;
            drop_q   <= '0;
            exc_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            live_q   <= live_d;
            drop_q   <= drop_d;
            if (w_push) begin
                exc_q[wr_ptr_q] <= w_misalign;
            end
        end
    end

    // PC payload needs no reset: it is only read when the count says valid.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            pc_mem_q[wr_ptr_q] <= bus.pc_i;
        end
    end

    assign bus.pc_ready_o          = w_pc_ready;
    assign bus.mem_req_valid_o     = w_req_valid;
    assign bus.mem_req_addr_o      = bus.pc_i;
    assign bus.mem_ans_ready_o     = w_ans_ready;
    assign bus.instr_valid_o       = w_instr_valid;
    assign bus.instr_o             = w_instr;
    assign bus.instr_pc_o          = w_instr_pc;
    assign bus.instr_except_o      = w_instr_except;
    assign bus.instr_except_code_o = w_instr_code;

`ifndef SYNTHESIS
    // Memory may only answer while some request (live or squashed) is owed.
    a_ans_owed : assert property (@(posedge clk_i) disable iff (!rst_ni)
        bus.mem_ans_valid_i |-> (w_owed != '0));
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_mem_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module    : tb_fetch_mem_if
// Purpose   : Self-checking bench for fetch_mem_if. Accepted PCs are pushed to
//             a scoreboard queue and popped when the stage emits the matching
//             instruction. Misaligned-PC scenario runs only when
//             FETCH_MISALIGN_CHECK_EN is defined.
// Revision  : 1.0 - initial release
// ============================================================================
module tb_fetch_mem_if;
    localparam int unsigned MAX_OUT = 2;
`ifdef FETCH_MISALIGN_CHECK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic flush;

    fetch_mem_if_if bus ();

    fetch_mem_if #(
        .MAX_OUTSTANDING (MAX_OUT),
        .BOOT_PC         (64'h0)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .flush_i (flush),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] exp_q [$];

    logic        s_pc_ready, s_req_valid, s_ans_ready, s_ivalid, s_iexc;
    logic [63:0] s_req_addr, s_ipc;
    logic [31:0] s_instr;
    logic [1:0]  s_icode;

    function automatic logic [63:0] front_pc();
        return (exp_q.size() != 0) ? exp_q[0] : 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction

    task automatic set_idle();
        bus.pc_valid_i       = 1'b0;
        bus.pc_i             = 64'h0;
        bus.mem_req_ready_i  = 1'b0;
        bus.mem_ans_valid_i  = 1'b0;
        bus.mem_ans_data_i   = 32'h0;
        bus.mem_ans_except_i = 1'b0;
        bus.instr_ready_i    = 1'b0;
        flush                = 1'b0;
    endtask

    // One clock of stimulus; outputs are sampled at the falling edge.
    task automatic cycle(input logic pv, input logic [63:0] pc, input logic rrdy,
                         input logic av, input logic [31:0] ad, input logic ae,
                         input logic irdy, input logic fl);
        bus.pc_valid_i       = pv;
        bus.pc_i             = pc;
        bus.mem_req_ready_i  = rrdy;
        bus.mem_ans_valid_i  = av;
        bus.mem_ans_data_i   = ad;
        bus.mem_ans_except_i = ae;
        bus.instr_ready_i    = irdy;
        flush                = fl;
        @(negedge clk);
        s_pc_ready  = bus.pc_ready_o;
        s_req_valid = bus.mem_req_valid_o;
        s_req_addr  = bus.mem_req_addr_o;
        s_ans_ready = bus.mem_ans_ready_o;
        s_ivalid    = bus.instr_valid_o;
        s_instr     = bus.instr_o;
        s_ipc       = bus.instr_pc_o;
        s_iexc      = bus.instr_except_o;
        s_icode     = bus.instr_except_code_o;
        if (fl) exp_q.delete();
        if (s_pc_ready) exp_q.push_back(pc);
        @(posedge clk);
        #1;
        set_idle();
    endtask

    task automatic offer(input logic [63:0] pc, input logic rrdy);
        cycle(1'b1, pc, rrdy, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic answer(input logic [31:0] data, input logic exc);
        cycle(1'b0, 64'h0, 1'b0, 1'b1, data, exc, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        set_idle();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.instr_valid_o !== 1'b0 || bus.pc_ready_o !== 1'b0 || bus.mem_req_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valids: got iv=%b pr=%b rv=%b, expected all 0",
                     bus.instr_valid_o, bus.pc_ready_o, bus.mem_req_valid_o);
        end
        n_checks++;
        if (bus.instr_o !== 32'h0 || bus.instr_pc_o !== 64'h0 || bus.instr_except_o !== 1'b0
            || bus.instr_except_code_o !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_data: got instr=%h pc=%h exc=%b code=%0d, expected zeros",
                     bus.instr_o, bus.instr_pc_o, bus.instr_except_o, bus.instr_except_code_o);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        cycle(1'b0, 64'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (s_pc_ready !== 1'b0 || s_req_valid !== 1'b0 || s_ivalid !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got pr=%b rv=%b iv=%b, expected 0 0 0",
                     s_pc_ready, s_req_valid, s_ivalid);
        end
    endtask

    task automatic test_basic_fetch();
        offer(64'h1000, 1'b0);
        n_checks++;
        if (s_req_valid !== 1'b1 || s_pc_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL req_stall: got rv=%b pr=%b, expected 1 0", s_req_valid, s_pc_ready);
        end
        offer(64'h1000, 1'b1);
        n_checks++;
        if (s_req_valid !== 1'b1 || s_pc_ready !== 1'b1 || s_req_addr !== 64'h1000) begin
            n_fail++;
            $display("FAIL req_issue: got rv=%b pr=%b addr=%h, expected 1 1 1000",
                     s_req_valid, s_pc_ready, s_req_addr);
        end
        cycle(1'b0, 64'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (s_ivalid !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_answer: got iv=%b, expected 0", s_ivalid);
        end
        cycle(1'b0, 64'h0, 1'b0, 1'b1, 32'h0000_0013, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (s_ivalid !== 1'b1 || s_ans_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL out_stall: got iv=%b ar=%b, expected 1 0", s_ivalid, s_ans_ready);
        end
        answer(32'h0000_0013, 1'b0);
        n_checks++;
        if (s_ivalid !== 1'b1 || s_ans_ready !== 1'b1 || s_instr !== 32'h13 || s_ipc !== front_pc()
            || s_ipc !== 64'h1000 || s_iexc !== 1'b0 || s_icode !== 2'd0) begin
            n_fail++;
            $display("FAIL basic_out: got iv=%b ar=%b instr=%h pc=%h exc=%b code=%0d, expected 1 1 13 1000 0 0",
                     s_ivalid, s_ans_ready, s_instr, s_ipc, s_iexc, s_icode);
        end
        void'(exp_q.pop_front());
        cycle(1'b0, 64'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (s_ivalid !== 1'b0 || s_instr !== 32'h0 || s_ipc !== 64'h0) begin
            n_fail++;
            $display("FAIL empty_after: got iv=%b instr=%h pc=%h, expected 0 0 0", s_ivalid, s_instr, s_ipc);
        end
    endtask

    task automatic test_backpressure();
        offer(64'h0, 1'b1);
        n_checks++;
        if (s_pc_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_first: got pr=%b, expected 1", s_pc_ready);
        end
        offer(64'h4, 1'b1);
        n_checks++;
        if (s_pc_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_second: got pr=%b, expected 1", s_pc_ready);
        end
        offer(64'h8, 1'b1);
        n_checks++;
        if (s_pc_ready !== 1'b0 || s_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_full: got pr=%b rv=%b, expected 0 0", s_pc_ready, s_req_valid);
        end
        // Pop while full: the slot is only usable from the next cycle.
        cycle(1'b1, 64'h8, 1'b1, 1'b1, 32'hA0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (s_pc_ready !== 1'b0 || s_ivalid !== 1'b1 || s_ipc !== front_pc() || s_ipc !== 64'h0
            || s_instr !== 32'hA0) begin
            n_fail++;
            $display("FAIL bp_pop_full: got pr=%b iv=%b pc=%h instr=%h, expected 0 1 0 a0",
                     s_pc_ready, s_ivalid, s_ipc, s_instr);
        end
        void'(exp_q.pop_front());
        offer(64'h8, 1'b1);
        n_checks++;
        if (s_pc_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_reopen: got pr=%b, expected 1", s_pc_ready);
        end
        answer(32'hA4, 1'b0);
        n_checks++;
        if (s_ivalid !== 1'b1 || s_ipc !== front_pc() || s_ipc !== 64'h4 || s_instr !== 32'hA4) begin
            n_fail++; $display("FAIL bp_out4: got iv=%b pc=%h instr=%h, expected 1 4 a4", s_ivalid, s_ipc, s_instr);
        end
        void'(exp_q.pop_front());
        answer(32'hA8, 1'b0);
        n_checks++;
        if (s_ivalid !== 1'b1 || s_ipc !== front_pc() || s_ipc !== 64'h8 || s_instr !== 32'hA8) begin
            n_fail++; $display("FAIL bp_out8: got iv=%b pc=%h instr=%h, expected 1 8 a8", s_ivalid, s_ipc, s_instr);
        end
        void'(exp_q.pop_front());
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        offer(64'h5000, 1'b1);
        n_checks++;
        if (s_pc_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_start: got pr=%b, expected 1", s_pc_ready);
        end
        for (int i = 1; i <= 8; i++) begin
            d = 32'hB000_0000 + 32'(i - 1);
            cycle(1'b1, 64'h5000 + 64'(4 * i), 1'b1, 1'b1, d, 1'b0, 1'b1, 1'b0);
            n_checks++;
            if (s_pc_ready !== 1'b1 || s_ivalid !== 1'b1 || s_ipc !== front_pc()
                || s_ipc !== 64'h5000 + 64'(4 * (i - 1)) || s_instr !== d) begin
                n_fail++;
                $display("FAIL b2b_%0d: got pr=%b iv=%b pc=%h instr=%h, expected 1 1 %h %h",
                         i, s_pc_ready, s_ivalid, s_ipc, s_instr, 64'h5000 + 64'(4 * (i - 1)), d);
            end
            void'(exp_q.pop_front());
        end
        answer(32'hB000_0008, 1'b0);
        n_checks++;
        if (s_ivalid !== 1'b1 || s_ipc !== front_pc() || s_ipc !== 64'h5020 || s_instr !== 32'hB000_0008) begin
            n_fail++; $display("FAIL b2b_last: got iv=%b pc=%h instr=%h, expected 1 5020 b0000008", s_ivalid, s_ipc, s_instr);
        end
        void'(exp_q.pop_front());
    endtask

    task automatic test_flush();
        offer(64'h100, 1'b1);
        offer(64'h104, 1'b1);
        cycle(1'b1, 64'h2000, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        n_checks++;
        if (s_ans_ready !== 1'b1 || s_ivalid !== 1'b0 || s_req_valid !== 1'b0 || s_pc_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_cycle: got ar=%b iv=%b rv=%b pr=%b, expected 1 0 0 0",
                     s_ans_ready, s_ivalid, s_req_valid, s_pc_ready);
        end
        offer(64'h2000, 1'b1);
        n_checks++;
        if (s_pc_ready !== 1'b0) begin
            n_fail++; $display("FAIL flush_drop2_noroom: got pr=%b, expected 0", s_pc_ready);
        end
        cycle(1'b1, 64'h2000, 1'b1, 1'b1, 32'hBAD0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (s_ivalid !== 1'b0 || s_ans_ready !== 1'b1 || s_pc_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_drop_a: got iv=%b ar=%b pr=%b, expected 0 1 0", s_ivalid, s_ans_ready, s_pc_ready);
        end
        cycle(1'b1, 64'h2000, 1'b1, 1'b1, 32'hBAD1, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (s_ivalid !== 1'b0 || s_ans_ready !== 1'b1 || s_pc_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_drop_b: got iv=%b ar=%b pr=%b, expected 0 1 1", s_ivalid, s_ans_ready, s_pc_ready);
        end
        answer(32'h55, 1'b0);
        n_checks++;
        if (s_ivalid !== 1'b1 || s_ipc !== front_pc() || s_ipc !== 64'h2000 || s_instr !== 32'h55) begin
            n_fail++; $display("FAIL flush_new_pc: got iv=%b pc=%h instr=%h, expected 1 2000 55", s_ivalid, s_ipc, s_instr);
        end
        void'(exp_q.pop_front());
    endtask

    task automatic test_flush_same_cycle();
        offer(64'h300, 1'b1);
        cycle(1'b0, 64'h0, 1'b0, 1'b1, 32'hBAD2, 1'b0, 1'b1, 1'b1);
        n_checks++;
        if (s_ans_ready !== 1'b1 || s_ivalid !== 1'b0) begin
            n_fail++; $display("FAIL flush_same_ans: got ar=%b iv=%b, expected 1 0", s_ans_ready, s_ivalid);
        end
        cycle(1'b0, 64'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (s_ivalid !== 1'b0 || s_ipc !== 64'h0) begin
            n_fail++; $display("FAIL flush_same_empty: got iv=%b pc=%h, expected 0 0", s_ivalid, s_ipc);
        end
        offer(64'h310, 1'b1);
        offer(64'h314, 1'b1);
        n_checks++;
        if (s_pc_ready !== 1'b1 || exp_q.size() != 2) begin
            n_fail++;
            $display("FAIL flush_same_room: got pr=%b queued=%0d, expected 1 2", s_pc_ready, exp_q.size());
        end
        answer(32'h61, 1'b0);
        n_checks++;
        if (s_ivalid !== 1'b1 || s_ipc !== front_pc() || s_ipc !== 64'h310 || s_instr !== 32'h61) begin
            n_fail++; $display("FAIL flush_same_out0: got iv=%b pc=%h instr=%h, expected 1 310 61", s_ivalid, s_ipc, s_instr);
        end
        void'(exp_q.pop_front());
        answer(32'h62, 1'b0);
        n_checks++;
        if (s_ivalid !== 1'b1 || s_ipc !== front_pc() || s_ipc !== 64'h314 || s_instr !== 32'h62) begin
            n_fail++; $display("FAIL flush_same_out1: got iv=%b pc=%h instr=%h, expected 1 314 62", s_ivalid, s_ipc, s_instr);
        end
        void'(exp_q.pop_front());
    endtask

    task automatic test_access_fault();
        offer(64'h3000, 1'b1);
        answer(32'hDEAD_BEEF, 1'b1);
        n_checks++;
        if (s_ivalid !== 1'b1 || s_iexc !== 1'b1 || s_icode !== 2'd0 || s_instr !== 32'h0
            || s_ipc !== front_pc() || s_ipc !== 64'h3000) begin
            n_fail++;
            $display("FAIL access_fault: got iv=%b exc=%b code=%0d instr=%h pc=%h, expected 1 1 0 0 3000",
                     s_ivalid, s_iexc, s_icode, s_instr, s_ipc);
        end
        void'(exp_q.pop_front());
    endtask

    task automatic test_misaligned();
        offer(64'h1000, 1'b1);
        offer(64'h1002, 1'b0);
        n_checks++;
        if (s_req_valid !== 1'b0 || s_pc_ready !== 1'b1) begin
            n_fail++; $display("FAIL mis_accept: got rv=%b pr=%b, expected 0 1", s_req_valid, s_pc_ready);
        end
        cycle(1'b0, 64'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (s_ivalid !== 1'b0) begin
            n_fail++; $display("FAIL mis_order_wait: got iv=%b, expected 0", s_ivalid);
        end
        answer(32'h77, 1'b0);
        n_checks++;
        if (s_ivalid !== 1'b1 || s_ipc !== front_pc() || s_ipc !== 64'h1000 || s_instr !== 32'h77 || s_iexc !== 1'b0) begin
            n_fail++; $display("FAIL mis_older: got iv=%b pc=%h instr=%h exc=%b, expected 1 1000 77 0", s_ivalid, s_ipc, s_instr, s_iexc);
        end
        void'(exp_q.pop_front());
        cycle(1'b0, 64'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (s_ivalid !== 1'b1 || s_iexc !== 1'b1 || s_icode !== 2'd1 || s_instr !== 32'h0
            || s_ipc !== front_pc() || s_ipc !== 64'h1002 || s_ans_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mis_out: got iv=%b exc=%b code=%0d instr=%h pc=%h ar=%b, expected 1 1 1 0 1002 0",
                     s_ivalid, s_iexc, s_icode, s_instr, s_ipc, s_ans_ready);
        end
        void'(exp_q.pop_front());
        // A flushed misaligned entry must not leave an owed answer behind.
        offer(64'h2002, 1'b0);
        cycle(1'b0, 64'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        offer(64'h2000, 1'b1);
        offer(64'h2004, 1'b1);
        n_checks++;
        if (s_pc_ready !== 1'b1 || exp_q.size() != 2) begin
            n_fail++; $display("FAIL mis_flush_nodrop: got pr=%b queued=%0d, expected 1 2", s_pc_ready, exp_q.size());
        end
        answer(32'h81, 1'b0);
        n_checks++;
        if (s_ivalid !== 1'b1 || s_ipc !== 64'h2000 || s_instr !== 32'h81) begin
            n_fail++; $display("FAIL mis_flush_out: got iv=%b pc=%h instr=%h, expected 1 2000 81", s_ivalid, s_ipc, s_instr);
        end
        void'(exp_q.pop_front());
        answer(32'h82, 1'b0);
        void'(exp_q.pop_front());
    endtask

    task automatic test_reset_mid();
        offer(64'h4000, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.instr_valid_o !== 1'b0 || bus.instr_pc_o !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_mid_clear: got iv=%b pc=%h, expected 0 0", bus.instr_valid_o, bus.instr_pc_o);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        exp_q.delete();
        offer(64'h4100, 1'b1);
        offer(64'h4104, 1'b1);
        n_checks++;
        if (s_pc_ready !== 1'b1 || exp_q.size() != 2) begin
            n_fail++; $display("FAIL reset_mid_room: got pr=%b queued=%0d, expected 1 2", s_pc_ready, exp_q.size());
        end
        answer(32'h91, 1'b0);
        n_checks++;
        if (s_ivalid !== 1'b1 || s_ipc !== front_pc() || s_ipc !== 64'h4100 || s_instr !== 32'h91) begin
            n_fail++; $display("FAIL reset_mid_out: got iv=%b pc=%h instr=%h, expected 1 4100 91", s_ivalid, s_ipc, s_instr);
        end
        void'(exp_q.pop_front());
        answer(32'h92, 1'b0);
        void'(exp_q.pop_front());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        set_idle();
        rst_n = 1'b0;
        test_reset();
        test_basic_fetch();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_flush_same_cycle();
        test_access_fault();
        if (MIS_EN) test_misaligned();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_mem_if.md
# fetch_mem_if

Frontend stage directly downstream of the PC generator. It accepts fetch PCs, issues instruction-memory requests, and tracks outstanding requests in an in-order PC FIFO. It pairs each memory answer with its PC and forwards the instruction to the issue queue. On flush it discards answers belonging to squashed requests. Its `pc_ready_o` drives the PC generator's memory-ready input.

## Interface
- `MAX_OUTSTANDING`, default 2: maximum in-flight requests, counting both live and squashed ones. Power of 2, at least 2.
- `BOOT_PC`, default 64'h0: not used for state. Kept for parameter symmetry with the frontend.
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `flush_i` in 1: squash all outstanding fetches. Asserted on misprediction or committed exception.
- `pc_valid_i` in 1: PC from the PC generator is valid.
- `pc_i` in 64: fetch PC.
- `pc_ready_o` out 1: PC accepted this cycle.
- `mem_req_valid_o` out 1: memory request valid.
- `mem_req_ready_i` in 1: memory accepts the request.
- `mem_req_addr_o` out 64: request address.
- `mem_ans_valid_i` in 1: memory answer valid.
- `mem_ans_ready_o` out 1: answer consumed.
- `mem_ans_data_i` in 32: instruction word.
- `mem_ans_except_i` in 1: access fault on this answer.
- `instr_valid_o` out 1: instruction to issue queue valid.
- `instr_ready_i` in 1: issue queue accepts.
- `instr_o` out 32: instruction word. Zero on exception.
- `instr_pc_o` out 64: PC of the instruction.
- `instr_except_o` out 1: exception attached.
- `instr_except_code_o` out 2: exception code. 0 = access fault, 1 = misaligned, others reserved.

## Operation
- **PC FIFO.** Depth `MAX_OUTSTANDING`. Each entry holds {pc, local_exc}. `live_cnt` = entries with local_exc=0, i.e. entries still awaiting a memory answer.
- **drop_cnt.** Width clog2(MAX_OUTSTANDING)+1. Counts answers still owed to squashed requests.
- **room.** `room = (fifo_cnt + drop_cnt) < MAX_OUTSTANDING`.
- **Request issue.**
  - `mem_req_valid_o = pc_valid_i & room & !flush_i`.
  - `mem_req_addr_o = pc_i`.
  - `pc_ready_o = mem_req_valid_o & mem_req_ready_i`.
  - On handshake, push {pc_i, 0}.
- **Answer routing.**
  - If `drop_cnt != 0`: `mem_ans_ready_o = 1`, the answer is discarded, and drop_cnt is decremented.
  - Else, if the FIFO head has local_exc=0: the answer passes to the output combinationally.
    - `instr_valid_o = mem_ans_valid_i & !flush_i`.
    - `mem_ans_ready_o = instr_ready_i & !flush_i`.
    - The head is popped on the output handshake.
    - `instr_except_o = mem_ans_except_i`, code 0.
- **Local-exception head.** When the head has local_exc=1, it is emitted without consuming any memory answer.
  - `instr_valid_o = !flush_i`, `instr_except_o = 1`, code 1, `instr_o = 0`.
  - The head is popped on `instr_ready_i`.
- **Protocol requirement on memory.** Answers arrive in request order, and only when `live_cnt + drop_cnt > 0`. An answer outside this condition is a protocol error and is asserted in simulation.
- **Flush.**
  - FIFO is cleared.
  - `drop_cnt_next = drop_cnt + live_cnt - (mem_ans_valid_i ? 1 : 0)`.
  - `mem_ans_ready_o = 1`; a same-cycle answer is discarded.
  - No request is issued and no output is produced that cycle.
- **Reset.**
  - FIFO empty, drop_cnt = 0.
  - With empty state, `instr_valid_o`, `pc_ready_o` and `mem_req_valid_o` are 0 whenever their enabling inputs are 0.
  - `instr_*` data outputs are 0 when the FIFO is empty.
  - Reset mid-operation abandons all tracking. The memory is reset by the same `rst_ni`.

## Timing
- Request path is combinational: `pc_valid_i` leads to `mem_req_valid_o` in the same cycle.
- Answer-to-instruction path has zero latency. FIFO and drop_cnt update at the clock edge.
- Simultaneous push and pop in one cycle is allowed, including when the FIFO is full: the pop frees a slot only from the next cycle, because `room` uses registered counts.
- FIFO pointers wrap modulo `MAX_OUTSTANDING`. An extra count bit distinguishes full from empty.
- Back-to-back requests at 1 per cycle are sustained while `room` holds and `instr_ready_i` drains.

## Configuration
- `FETCH_MISALIGN_CHECK_EN`, when defined:
  - A PC with `pc_i[1:0] != 0` sends no memory request.
  - Such a PC is accepted when `room & !flush_i`, i.e. `pc_ready_o = 1` independent of `mem_req_ready_i`, and {pc_i, 1} is pushed.
  - On flush, these entries are cleared without incrementing drop_cnt.
- When undefined:
  - No alignment check. Every PC goes to memory unchanged.
  - local_exc is always 0, and code 1 is never produced.

## Test plan
- **Basic fetch.** Reset, then PC 0x1000 valid with mem ready; answer 0x00000013 two cycles later.
  - Expect `instr_valid_o=1`, `instr_o=0x13`, `instr_pc_o=0x1000`, exception flag 0.
- **Back-pressure.** `MAX_OUTSTANDING=2`, PCs 0x0, 0x4, 0x8 offered with no answers.
  - Expect two handshakes, then `pc_ready_o=0` until an answer pops.
- **Flush.** Two requests outstanding, then `flush_i` asserted.
  - Expect drop_cnt=2; the next two answers are consumed with `instr_valid_o=0`.
  - A new PC 0x2000 is answered with `instr_pc_o=0x2000`.
- **Flush with same-cycle answer.** One request outstanding, flush and answer in the same cycle.
  - Expect the answer discarded, drop_cnt=0, and the FIFO empty the next cycle.
- **Access fault.** Answer carries `mem_ans_except_i=1` for PC 0x3000.
  - Expect `instr_except_o=1`, code 0, `instr_pc_o=0x3000`.
- **Misaligned PC (macro on).** PC 0x1002 offered.
  - Expect `mem_req_valid_o=0`, `pc_ready_o=1`, then output with exception flag 1, code 1, PC 0x1002, after any older entries.
